// File: rtl/id_ex_pipeline_register_if.sv
// ID/EX boundary bundle: hazard controls, ID-stage fields in, EX-stage fields and perf counters out.
interface id_ex_pipeline_register_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 4,
    parameter int CNT_WIDTH   = 16
);
    logic                   Stall;
    logic                   Flush;
    logic                   ValidIn;
    logic [DATA_WIDTH-1:0]  PCPlus4In;
    logic [DATA_WIDTH-1:0]  ReadData1In;
    logic [DATA_WIDTH-1:0]  ReadData2In;
    logic [DATA_WIDTH-1:0]  ImmExtIn;
    logic [4:0]             RtIn;
    logic [4:0]             RdIn;
    logic [4:0]             ShamtIn;
    logic [7:0]             CtrlIn;
    logic [ALUOP_WIDTH-1:0] ALUOpIn;

    logic                   ValidOut;
    logic [DATA_WIDTH-1:0]  PCPlus4Out;
    logic [DATA_WIDTH-1:0]  ReadData1Out;
    logic [DATA_WIDTH-1:0]  ReadData2Out;
    logic [DATA_WIDTH-1:0]  ImmExtOut;
    logic [4:0]             RtOut;
    logic [4:0]             RdOut;
    logic [4:0]             ShamtOut;
    logic [7:0]             CtrlOut;
    logic [ALUOP_WIDTH-1:0] ALUOpOut;
    logic [CNT_WIDTH-1:0]   BubbleCount;
    logic [CNT_WIDTH-1:0]   StallCount;

    modport master (
        output Stall, Flush, ValidIn, PCPlus4In, ReadData1In, ReadData2In, ImmExtIn,
               RtIn, RdIn, ShamtIn, CtrlIn, ALUOpIn,
        input  ValidOut, PCPlus4Out, ReadData1Out, ReadData2Out, ImmExtOut,
               RtOut, RdOut, ShamtOut, CtrlOut, ALUOpOut, BubbleCount, StallCount
    );

    modport slave (
        input  Stall, Flush, ValidIn, PCPlus4In, ReadData1In, ReadData2In, ImmExtIn,
               RtIn, RdIn, ShamtIn, CtrlIn, ALUOpIn,
        output ValidOut, PCPlus4Out, ReadData1Out, ReadData2Out, ImmExtOut,
               RtOut, RdOut, ShamtOut, CtrlOut, ALUOpOut, BubbleCount, StallCount
    );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with stall/flush, valid tracking and saturating bubble/stall counters.
module id_ex_pipeline_register #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    id_ex_pipeline_register_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_pc4;
    logic [DATA_WIDTH-1:0]  r_rd1;
    logic [DATA_WIDTH-1:0]  r_rd2;
    logic [DATA_WIDTH-1:0]  r_imm;
    logic [4:0]             r_rt;
    logic [4:0]             r_rd;
    logic [4:0]             r_shamt;
    logic [7:0]             r_ctrl;
    logic [ALUOP_WIDTH-1:0] r_aluop;
    logic [CNT_WIDTH-1:0]   r_bubble_cnt;
    logic [CNT_WIDTH-1:0]   r_stall_cnt;

    // Flush beats Stall: a bubble is loaded even when the hazard unit also asks to hold.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_valid      <= 1'b0;
            r_pc4        <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_shamt      <= '0;
            r_ctrl       <= '0;
            r_aluop      <= '0;
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else if (bus.Flush) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_shamt <= '0;
            r_ctrl  <= '0;
            r_aluop <= '0;
            if (r_bubble_cnt != CNT_MAX) r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end else if (bus.Stall) begin
            if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_valid <= bus.ValidIn;
            r_pc4   <= bus.PCPlus4In;
            r_rd1   <= bus.ReadData1In;
            r_rd2   <= bus.ReadData2In;
            r_imm   <= bus.ImmExtIn;
            r_rt    <= bus.RtIn;
            r_rd    <= bus.RdIn;
            r_shamt <= bus.ShamtIn;
            // Invalid slots carry no control so later stages cannot write state.
            r_ctrl  <= bus.ValidIn ? bus.CtrlIn : 8'h00;
            r_aluop <= bus.ALUOpIn;
        end
    end

    assign bus.ValidOut     = r_valid;
    assign bus.PCPlus4Out   = r_pc4;
    assign bus.ReadData1Out = r_rd1;
    assign bus.ReadData2Out = r_rd2;
    assign bus.ImmExtOut    = r_imm;
    assign bus.RtOut        = r_rt;
    assign bus.RdOut        = r_rd;
    assign bus.ShamtOut     = r_shamt;
    assign bus.CtrlOut      = r_ctrl;
    assign bus.ALUOpOut     = r_aluop;
    assign bus.BubbleCount  = r_bubble_cnt;
    assign bus.StallCount   = r_stall_cnt;
endmodule
